// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: bundles both master ports, the interconnect port and the grant status of wb_arbiter2
interface wb_arbiter2_if;
   logic        m0_cyc, m0_stb, m0_we, m0_stall, m0_ack;
   logic [15:0] m0_adr, m0_dat_o, m0_dat_i;
   logic        m1_cyc, m1_stb, m1_we, m1_stall, m1_ack;
   logic [15:0] m1_adr, m1_dat_o, m1_dat_i;
   logic        s_cyc, s_stb, s_we, s_stall, s_ack;
   logic [15:0] s_adr, s_dat_o, s_dat_i;
   logic [1:0]  gnt;
   modport slave (
      input  m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o,
      input  m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o,
      input  s_dat_i, s_stall, s_ack,
      output m0_dat_i, m0_stall, m0_ack, m1_dat_i, m1_stall, m1_ack,
      output s_cyc, s_stb, s_we, s_adr, s_dat_o, gnt
   );
   modport master (
      output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_o,
      output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o,
      output s_dat_i, s_stall, s_ack,
      input  m0_dat_i, m0_stall, m0_ack, m1_dat_i, m1_stall, m1_ack,
      input  s_cyc, s_stb, s_we, s_adr, s_dat_o, gnt
   );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin pipelined Wishbone arbiter with outstanding-request throttling
// WB_ARB_FIXED_PRIO_EN selects fixed priority (master 0 always wins) instead of round-robin.
module wb_arbiter2 #(
   parameter int MAX_OUTST = 4,
   parameter int CW        = 4
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter2_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          w_g0, w_g1, w_full, w_inc, w_dec, w_pick0;
   logic [CW-1:0] w_cnt_nxt;
   state_t        w_rel0;
`ifdef WB_ARB_FIXED_PRIO_EN
   assign w_pick0 = 1'b1;
   // Releasing master 0 returns to IDLE so it can win again if it re-requests
   assign w_rel0  = IDLE;
`else
   logic r_last;
   assign w_pick0 = r_last;
   assign w_rel0  = bus.m1_cyc ? GNT1 : IDLE;
`endif
   assign w_g0      = (r_state == GNT0) && !rst;
   assign w_g1      = (r_state == GNT1) && !rst;
   assign w_full    = r_cnt == CW'(MAX_OUTST);
   assign bus.s_cyc = w_g0 ? bus.m0_cyc : w_g1 ? bus.m1_cyc : 1'b0;
   assign bus.s_stb = (w_g0 ? bus.m0_stb : w_g1 ? bus.m1_stb : 1'b0) & !w_full;
   assign bus.s_we    = w_g1 ? bus.m1_we    : bus.m0_we;
   assign bus.s_adr   = w_g1 ? bus.m1_adr   : bus.m0_adr;
   assign bus.s_dat_o = w_g1 ? bus.m1_dat_o : bus.m0_dat_o;
   assign bus.m0_stall = w_g0 ? (bus.s_stall | w_full) : 1'b1;
   assign bus.m1_stall = w_g1 ? (bus.s_stall | w_full) : 1'b1;
   assign bus.m0_ack   = w_g0 & bus.s_ack;
   assign bus.m1_ack   = w_g1 & bus.s_ack;
   assign bus.m0_dat_i = w_g0 ? bus.s_dat_i : 16'h0000;
   assign bus.m1_dat_i = w_g1 ? bus.s_dat_i : 16'h0000;
   assign bus.gnt      = {w_g1, w_g0};
   // Spurious acks at cnt=0 are forwarded but never underflow the counter
   assign w_inc     = bus.s_stb & !bus.s_stall;
   assign w_dec     = bus.s_ack & (r_cnt != '0);
   assign w_cnt_nxt = r_cnt + CW'(w_inc) - CW'(w_dec);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
         r_last  <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt   <= '0;
               r_state <= (bus.m0_cyc && (!bus.m1_cyc || w_pick0)) ? GNT0 : bus.m1_cyc ? GNT1 : IDLE;
            end
            GNT0: if (bus.m0_cyc) r_cnt <= w_cnt_nxt;
               else begin
                  r_cnt   <= '0;
                  r_state <= w_rel0;
`ifndef WB_ARB_FIXED_PRIO_EN
                  r_last  <= 1'b0;
`endif
               end
            GNT1: if (bus.m1_cyc) r_cnt <= w_cnt_nxt;
               else begin
                  r_cnt   <= '0;
                  r_state <= bus.m0_cyc ? GNT0 : IDLE;
`ifndef WB_ARB_FIXED_PRIO_EN
                  r_last  <= 1'b1;
`endif
               end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
